seq_detector_1011: RTL and testbench

Moore-style serial pattern detector that consumes the registered bit stream produced by the `dff` stage: `din` is driven directly from the flip-flop's `q`. Each enabled clock it advances a 5-state FSM looking for the pattern 1011, in selectable overlapping or non-overlapping mode. On each match it emits a one-cycle registered `detect` pulse and increments a saturating match counter. It is the first consumer stage in the seqlogic serial path.

---
 rtl/seq_detector_1011.sv | 84 ++++++++
 tb/tb_seq_detector_1011.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_detector_1011.sv
// seq_detector_1011: Moore detector for the serial pattern 1011.
// A 5-state FSM advances on enabled edges. Overlapping or non-overlapping
// mode is chosen by `overlap`. Each entry into the match state produces a
// registered one-cycle `detect` pulse and bumps a saturating match counter.
// Handshake: there is no valid/ready; `en` qualifies `din` on each rising edge,
// and edges with en=0 leave state and count untouched.
module seq_detector_1011 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             en,
   input  logic             overlap,
   input  logic             clr_cnt,
   output logic             detect,
   output logic [CNT_W-1:0] count,
   output logic [2:0]       state_out
);

   // State encodings double as the debug view on state_out.
   localparam logic [2:0] S0 = 3'd0;  // nothing matched
   localparam logic [2:0] S1 = 3'd1;  // "1"
   localparam logic [2:0] S2 = 3'd2;  // "10"
   localparam logic [2:0] S3 = 3'd3;  // "101"
   localparam logic [2:0] S4 = 3'd4;  // "1011" matched

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic             detect_q, detect_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             match;

   // Next-state logic. Illegal encodings recover to S0 even when en=0.
   always_comb begin
      state_d = state_q;
      if (state_q > S4) begin
         state_d = S0;
      end else if (en) begin
         case (state_q)
            S0:      state_d = din ? S1 : S0;
            S1:      state_d = din ? S1 : S2;
            S2:      state_d = din ? S3 : S0;
            S3:      state_d = din ? S4 : S2;
            S4:      state_d = din ? S1 : (overlap ? S2 : S0);
            default: state_d = S0;
         endcase
      end
   end

   // Match qualifier, then the detect pulse and saturating counter update.
   // A clear that coincides with a match leaves the count at 1 so the match
   // still gets counted.
   always_comb begin
      match    = en && (state_d == S4);
      detect_d = match;
      count_d  = count_q;
      if (clr_cnt) begin
         count_d = match ? CNT_ONE : '0;
      end else if (match && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_ONE;
      end
   end

   // Registers with synchronous active-high reset overriding all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S0;
         detect_q <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         detect_q <= detect_d;
         count_q  <= count_d;
      end
   end

   assign detect    = detect_q;
   assign count     = count_q;
   assign state_out = state_q;

endmodule

// File: tb/tb_seq_detector_1011.sv
// tb_seq_detector_1011: directed bench for the 1011 detector.
// Two instances share every input: one with the default 8-bit counter and
// one with a 2-bit counter so saturation can be reached quickly.
module tb_seq_detector_1011;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b0;
   logic       en = 1'b0;
   logic       overlap = 1'b1;
   logic       clr_cnt = 1'b0;
   logic       det8, det2;
   logic [7:0] cnt8;
   logic [1:0] cnt2;
   logic [2:0] st8, st2;

   int n_checks = 0;
   int n_pass = 0;

   // clock / reset block
   always #5 clk = ~clk;

   seq_detector_1011 #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .din(din), .en(en), .overlap(overlap),
      .clr_cnt(clr_cnt), .detect(det8), .count(cnt8), .state_out(st8)
   );

   seq_detector_1011 #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .din(din), .en(en), .overlap(overlap),
      .clr_cnt(clr_cnt), .detect(det2), .count(cnt2), .state_out(st2)
   );

   // comparison helper
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // driver: apply inputs, take one edge, settle 1ns past it
   task automatic drive(input logic r, input logic d, input logic e);
      rst = r;
      din = d;
      en  = e;
      @(posedge clk);
      #1;
   endtask

   // one enabled/disabled bit followed by detect and state checks on both DUTs
   task automatic bit_chk(input string tag, input logic d, input logic e,
                          input logic exp_det, input logic [2:0] exp_st);
      drive(1'b0, d, e);
      chk({tag, "_det8"}, {7'd0, det8}, {7'd0, exp_det});
      chk({tag, "_det2"}, {7'd0, det2}, {7'd0, exp_det});
      chk({tag, "_st8"}, {5'd0, st8}, {5'd0, exp_st});
      chk({tag, "_st2"}, {5'd0, st2}, {5'd0, exp_st});
   endtask

   task automatic cnt_chk(input string tag, input logic [7:0] e8, input logic [1:0] e2);
      chk({tag, "_cnt8"}, cnt8, e8);
      chk({tag, "_cnt2"}, {6'd0, cnt2}, {6'd0, e2});
   endtask

   initial begin
      // reset: two edges with din=1, en=1
      #1;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1);
      chk("rst_det", {7'd0, det8}, 8'd0);
      chk("rst_st", {5'd0, st8}, 8'd0);
      cnt_chk("rst", 8'd0, 2'd0);

      // first pattern 1011
      overlap = 1'b1;
      bit_chk("p1_b1", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("p1_b2", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("p1_b3", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("p1_b4", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("p1", 8'd1, 2'd1);
      bit_chk("p1_b5", 1'b0, 1'b1, 1'b0, 3'd2);

      // overlapping: 1011011 -> matches on bits 4 and 7
      drive(1'b1, 1'b0, 1'b0);
      bit_chk("ov_b1", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("ov_b2", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("ov_b3", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("ov_b4", 1'b1, 1'b1, 1'b1, 3'd4);
      bit_chk("ov_b5", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("ov_b6", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("ov_b7", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("ov", 8'd2, 2'd2);

      // non-overlapping: 1011011 -> one match; S4 -0-> S0 -1-> S1 -1-> S1
      drive(1'b1, 1'b0, 1'b0);
      overlap = 1'b0;
      bit_chk("no_b1", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("no_b2", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("no_b3", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("no_b4", 1'b1, 1'b1, 1'b1, 3'd4);
      bit_chk("no_b5", 1'b0, 1'b1, 1'b0, 3'd0);
      bit_chk("no_b6", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("no_b7", 1'b1, 1'b1, 1'b0, 3'd1);
      cnt_chk("no", 8'd1, 2'd1);

      // enable gaps inside a pattern are transparent
      drive(1'b1, 1'b0, 1'b0);
      overlap = 1'b1;
      bit_chk("gap_b1", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("gap_b2", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("gap_g1", 1'b1, 1'b0, 1'b0, 3'd2);
      bit_chk("gap_g2", 1'b0, 1'b0, 1'b0, 3'd2);
      bit_chk("gap_g3", 1'b1, 1'b0, 1'b0, 3'd2);
      bit_chk("gap_b3", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("gap_b4", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("gap", 8'd1, 2'd1);

      // counter corners: four overlapping matches, 2-bit counter saturates
      drive(1'b1, 1'b0, 1'b0);
      bit_chk("sat_a1", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("sat_a2", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("sat_a3", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("sat_a4", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("sat_m1", 8'd1, 2'd1);
      bit_chk("sat_b1", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("sat_b2", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("sat_b3", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("sat_m2", 8'd2, 2'd2);
      bit_chk("sat_c1", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("sat_c2", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("sat_c3", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("sat_m3", 8'd3, 2'd3);
      bit_chk("sat_d1", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("sat_d2", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("sat_d3", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("sat_m4", 8'd4, 2'd3);
      // clear coinciding with a match keeps that match
      bit_chk("clr_e1", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("clr_e2", 1'b1, 1'b1, 1'b0, 3'd3);
      clr_cnt = 1'b1;
      bit_chk("clr_e3", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("clr_match", 8'd1, 2'd1);
      // clear alone
      bit_chk("clr_f1", 1'b0, 1'b1, 1'b0, 3'd2);
      cnt_chk("clr_only", 8'd0, 2'd0);
      clr_cnt = 1'b0;

      // reset mid-pattern discards progress
      drive(1'b1, 1'b0, 1'b0);
      bit_chk("mid_b1", 1'b1, 1'b1, 1'b0, 3'd1);
      bit_chk("mid_b2", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("mid_b3", 1'b1, 1'b1, 1'b0, 3'd3);
      drive(1'b1, 1'b1, 1'b1);
      chk("mid_rst_st", {5'd0, st8}, 8'd0);
      bit_chk("mid_b4", 1'b1, 1'b1, 1'b0, 3'd1);
      cnt_chk("mid_nomatch", 8'd0, 2'd0);
      bit_chk("mid_c1", 1'b0, 1'b1, 1'b0, 3'd2);
      bit_chk("mid_c2", 1'b1, 1'b1, 1'b0, 3'd3);
      bit_chk("mid_c3", 1'b1, 1'b1, 1'b1, 3'd4);
      cnt_chk("mid_match", 8'd1, 2'd1);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
